// File: rtl/antidroop_seq_ctrl.sv
// Anti-droop IIR channel sequencer: trigger sync, CLEAR/ACTIVE/HOLDOFF pulse timing,
// shadowed tap-weight updates applied only in IDLE, and overflow monitoring with auto-kill.
module antidroop_seq_ctrl #(
  parameter int WIN_W = 12,
  parameter int HOLDOFF_CYC = 16,
  parameter logic signed [6:0] INIT_WEIGHT = 7'sd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trig,
  input  logic                enable,
  input  logic [WIN_W-1:0]    win_len,
  input  logic                cfg_wr,
  input  logic signed [6:0]   cfg_weight,
  input  logic                auto_kill_en,
  input  logic                oflow_in,
  input  logic                oflow_clr,
  output logic signed [6:0]   tap_weight,
  output logic                iir_trig,
  output logic                acc_clr_en,
  output logic                active,
  output logic                cfg_pending,
  output logic                cfg_ack,
  output logic                killed,
  output logic                oflow_sticky,
  output logic [7:0]          oflow_count,
  output logic [15:0]         pulse_count
);

  localparam int HC_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, ACTIVE, HOLDOFF} state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic [WIN_W-1:0]    win_cnt;
  logic [HC_W-1:0]     hold_cnt;
  logic signed [6:0]   shadow;
  logic                win_oflow;

  logic                trig_edge;
  logic                apply;
  logic                win_done;
  logic                oflow_inc;
  logic                kill;
  logic [WIN_W-1:0]    win_load;

  assign trig_edge = s2 & ~s3;
  assign apply     = (state == IDLE) && cfg_pending;
  assign win_done  = (state == ACTIVE) && (win_cnt == WIN_W'(1));
  // An overflow in the final window cycle still counts towards that window.
  assign oflow_inc = win_done && (win_oflow || oflow_in);
  assign kill      = auto_kill_en && oflow_in && ((state == CLEAR) || (state == ACTIVE));
  assign win_load  = (win_len == '0) ? WIN_W'(1) : win_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      win_cnt      <= '0;
      hold_cnt     <= '0;
      shadow       <= '0;
      win_oflow    <= 1'b0;
      tap_weight   <= INIT_WEIGHT;
      iir_trig     <= 1'b0;
      acc_clr_en   <= 1'b0;
      active       <= 1'b0;
      cfg_pending  <= 1'b0;
      cfg_ack      <= 1'b0;
      killed       <= 1'b0;
      oflow_sticky <= 1'b0;
      oflow_count  <= '0;
      pulse_count  <= '0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      s3 <= s2;

      iir_trig   <= 1'b0;
      acc_clr_en <= 1'b0;
      cfg_ack    <= 1'b0;

      case (state)
        IDLE: begin
          if (trig_edge && enable) begin
            state      <= CLEAR;
            iir_trig   <= 1'b1;
            acc_clr_en <= 1'b1;
            active     <= 1'b1;
          end
        end
        CLEAR: begin
          win_cnt     <= win_load;
          pulse_count <= pulse_count + 16'd1;
          state       <= ACTIVE;
        end
        ACTIVE: begin
          if (win_done) begin
            state    <= HOLDOFF;
            active   <= 1'b0;
            hold_cnt <= HC_LOAD;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - HC_W'(1);
        end
        default: state <= IDLE;
      endcase

      // A write coinciding with an apply lands in the shadow and stays pending.
      if (cfg_wr) begin
        shadow      <= cfg_weight;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end

      if (apply) begin
        tap_weight <= shadow;
        cfg_ack    <= 1'b1;
        killed     <= 1'b0;
      end else if (kill) begin
        tap_weight <= '0;
        killed     <= 1'b1;
      end

      if (oflow_in)       oflow_sticky <= 1'b1;
      else if (oflow_clr) oflow_sticky <= 1'b0;

      if (win_done)                           win_oflow <= 1'b0;
      else if (oflow_in && (state == ACTIVE)) win_oflow <= 1'b1;

      if (oflow_inc) begin
        if (oflow_clr)                 oflow_count <= 8'd1;
        else if (oflow_count != 8'hFF) oflow_count <= oflow_count + 8'd1;
      end else if (oflow_clr) begin
        oflow_count <= '0;
      end
    end
  end

endmodule

// File: doc/antidroop_seq_ctrl.md
Name: antidroop_seq_ctrl

Overview:
- Per-channel sequencer and configuration controller for the anti-droop IIR datapath. It synchronises the external pulse trigger, drives the IIR trigger and accumulator-clear enable, and times the pulse window.
- It takes tap-weight updates from the control register bus through a shadow register and applies them only between pulses.
- It monitors the IIR overflow flag: sticky status, per-window overflow count, and optional automatic weight kill.

Parameters:
- WIN_W, 12, width of window-length input and window counter.
- HOLDOFF_CYC, 16, cycles spent in HOLDOFF after each window (min 1).
- INIT_WEIGHT, 0, signed 7-bit tap weight loaded at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- trig  in  1  external pulse trigger, asynchronous to clk.
- enable  in  1  allows new windows to start.
- win_len  in  WIN_W  window length in cycles; 0 treated as 1.
- cfg_wr  in  1  one-cycle strobe: write cfg_weight to shadow.
- cfg_weight  in  7  signed requested tap weight.
- auto_kill_en  in  1  force tap_weight to 0 on overflow.
- oflow_in  in  1  overflow flag from IIR.
- oflow_clr  in  1  clear sticky flag and overflow count.
- tap_weight  out  7  signed weight to IIR.
- iir_trig  out  1  one-cycle trigger pulse to IIR.
- acc_clr_en  out  1  accumulator clear enable to IIR.
- active  out  1  high in CLEAR and ACTIVE.
- cfg_pending  out  1  shadow holds an unapplied weight.
- cfg_ack  out  1  one-cycle pulse when shadow is applied.
- killed  out  1  weight forced to 0 by auto-kill.
- oflow_sticky  out  1  overflow seen since last clear.
- oflow_count  out  8  windows with overflow, saturating.
- pulse_count  out  16  windows started, wrapping.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE and trigger sync flops are 0.
  - tap_weight = INIT_WEIGHT.
  - All other outputs and counters are 0, including the shadow register.
- Trigger path:
  - trig passes through 2 sync flops, then an edge register.
  - trig_edge = s2 & ~s3, so it occurs 3 clk edges after trig rises.
- IDLE:
  - If trig_edge && enable, go to CLEAR; otherwise stay.
  - trig_edge with enable low is ignored.
- CLEAR (exactly 1 cycle):
  - iir_trig = 1 and acc_clr_en = 1.
  - Window counter loads max(win_len, 1), with win_len sampled this cycle.
  - pulse_count increments (wraps 0xFFFF to 0).
  - Next state is ACTIVE.
- ACTIVE:
  - Counter decrements every cycle; when it equals 1, go to HOLDOFF.
  - The window therefore lasts exactly max(win_len, 1) cycles.
  - trig_edge is ignored. Deasserting enable does not abort the window.
- HOLDOFF:
  - Lasts HOLDOFF_CYC cycles, then go to IDLE.
  - trig_edge is ignored.
- Outputs:
  - iir_trig and acc_clr_en are 0 outside CLEAR.
  - active = 1 in CLEAR and ACTIVE, registered.
- Configuration:
  - cfg_wr in any state loads the shadow register and sets cfg_pending on the next edge.
  - A second cfg_wr before the weight is applied overwrites the shadow; only one ack is issued.
  - A pending weight is applied on any cycle where state == IDLE and cfg_pending = 1: tap_weight takes the shadow value, cfg_pending clears, cfg_ack pulses for 1 cycle, and killed clears.
  - This includes the IDLE cycle that transitions to CLEAR. In that case the new weight is valid from the CLEAR cycle onward.
  - cfg_wr in the same cycle as an apply: the apply uses the old shadow, and the new value loads and remains pending.
  - tap_weight never changes in CLEAR, ACTIVE or HOLDOFF, except for auto-kill.
- Overflow:
  - oflow_in is sampled in all states.
  - oflow_in = 1 sets oflow_sticky.
  - If oflow_in = 1 in ACTIVE, a per-window flag is set.
  - On the ACTIVE→HOLDOFF transition with the window flag set, oflow_count increments (saturating at 255) and the window flag clears.
  - oflow_clr clears oflow_sticky and oflow_count. If oflow_clr and a set or increment occur in the same cycle, the set wins and the count becomes 1.
  - Auto-kill: if auto_kill_en and oflow_in are both 1 in CLEAR or ACTIVE, then next cycle tap_weight = 0 and killed = 1. Both hold until the next weight apply.

Test Plan:
- Reset, then trig rising at cycle 0 with enable = 1 and win_len = 10 → iir_trig and acc_clr_en pulse high for 1 cycle at edge 3; active high for 11 cycles; IDLE again after 10 + 1 + 16 cycles; pulse_count = 1.
- cfg_wr with cfg_weight = 63 during ACTIVE → cfg_pending = 1 and tap_weight unchanged until IDLE; then tap_weight = 63 and cfg_ack is a single 1-cycle pulse. A second write of −5 before IDLE yields only −5 and one ack.
- win_len = 0 → window lasts 1 cycle. Extra trig edges during ACTIVE or HOLDOFF do not restart the window; pulse_count increments once.
- oflow_in pulsed in 3 separate windows → oflow_count = 3 and oflow_sticky = 1. oflow_clr coinciding with a 4th increment → count = 1. 300 overflow windows → count holds at 255.
- auto_kill_en = 1, tap_weight = 20, oflow_in in ACTIVE → tap_weight = 0 and killed = 1 the next cycle; a later cfg_wr of 10 applies in IDLE with killed = 0.
- rst_n asserted mid-ACTIVE, asynchronously → all outputs are immediately at reset values and tap_weight = INIT_WEIGHT; after release, the next trig starts a fresh window.
